// File: rtl/sdram_burst_scheduler_pkg.sv
// Shared types and default constants for the SDRAM burst scheduler.
package sdram_burst_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_t;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } grant_t;

  localparam int unsigned DEF_ADDR_W     = 23;
  localparam int unsigned DEF_LEN_W      = 9;
  localparam int unsigned DEF_USED_W     = 10;
  localparam int unsigned DEF_FIFO_DEPTH = 512;
  localparam int unsigned DEF_BURST_LEN  = 256;
  localparam int unsigned DEF_WR_BASE    = 0;
  localparam int unsigned DEF_WR_MAX     = 307200;
  localparam int unsigned DEF_RD_BASE    = 0;
  localparam int unsigned DEF_RD_MAX     = 307200;

endpackage

// File: rtl/sdram_burst_scheduler_burst_addr_gen.sv
// Per-port frame pointer: burst length clipping, advance/wrap and deferred rewind.
module burst_addr_gen
  import sdram_burst_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned BASE      = 0,
  parameter int unsigned MAX       = DEF_WR_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              active,
  input  logic              done,
  output logic [ADDR_W-1:0] issue_addr,
  output logic [LEN_W-1:0]  issue_len
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   MAX_X   = (ADDR_W + 1)'(MAX);
  localparam logic [ADDR_W:0]   BURST_X = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [LEN_W-1:0]  BURST_L = LEN_W'(BURST_LEN);

  logic [ADDR_W-1:0] ptr;
  logic              pend;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W:0]   nxt;

  // An idle-time rewind is forwarded so a burst granted in the same cycle starts at BASE.
  always_comb begin
    cur = (load && !active) ? BASE_A : ptr;
    rem = MAX_X - {1'b0, cur};
    if (rem < BURST_X) issue_len = rem[LEN_W-1:0];
    else               issue_len = BURST_L;
    issue_addr = cur;
    nxt = {1'b0, ptr} + (ADDR_W + 1)'(issue_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= BASE_A;
      pend <= 1'b0;
    end else if (done) begin
      pend <= 1'b0;
      if (load || pend || (nxt >= MAX_X)) ptr <= BASE_A;
      else                                ptr <= nxt[ADDR_W-1:0];
    end else if (load) begin
      if (active) pend <= 1'b1;
      else        ptr  <= BASE_A;
    end
  end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Round-robin scheduler of write (camera) and read (VGA) SDRAM bursts.
module sdram_burst_scheduler
  import sdram_burst_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned USED_W     = DEF_USED_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned WR_BASE    = DEF_WR_BASE,
  parameter int unsigned WR_MAX     = DEF_WR_MAX,
  parameter int unsigned RD_BASE    = DEF_RD_BASE,
  parameter int unsigned RD_MAX     = DEF_RD_MAX
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WR_LOAD,
  input  logic              RD_LOAD,
  input  logic [USED_W-1:0] WR_USED,
  input  logic [USED_W-1:0] RD_USED,
  output logic              CMD_VALID,
  input  logic              CMD_READY,
  output logic              CMD_WRITE,
  output logic [ADDR_W-1:0] CMD_ADDR,
  output logic [LEN_W-1:0]  CMD_LEN,
  input  logic              CMD_DONE,
  output logic              BUSY
);

  localparam logic [USED_W-1:0] WR_THRESH = USED_W'(BURST_LEN);
  localparam logic [USED_W-1:0] RD_THRESH = USED_W'(FIFO_DEPTH - BURST_LEN);

  state_t state;
  grant_t gnt;
  grant_t last_grant;
  grant_t pick;

  logic              wr_req, rd_req;
  logic              wr_active, rd_active;
  logic              wr_done, rd_done;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [LEN_W-1:0]  wr_len, rd_len;

  always_comb begin
    wr_req    = (WR_USED >= WR_THRESH);
    rd_req    = (RD_USED <= RD_THRESH);
    wr_active = (state != ST_IDLE) && (gnt == GNT_WR);
    rd_active = (state != ST_IDLE) && (gnt == GNT_RD);
    wr_done   = CMD_DONE && (state == ST_WAIT_DONE) && (gnt == GNT_WR);
    rd_done   = CMD_DONE && (state == ST_WAIT_DONE) && (gnt == GNT_RD);
    pick      = GNT_WR;
    if (wr_req && rd_req) pick = (last_grant == GNT_RD) ? GNT_WR : GNT_RD;
    else if (rd_req)      pick = GNT_RD;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      gnt        <= GNT_WR;
      last_grant <= GNT_RD;
      CMD_VALID  <= 1'b0;
      CMD_WRITE  <= 1'b0;
      CMD_ADDR   <= '0;
      CMD_LEN    <= '0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_req || rd_req) begin
            state      <= ST_ISSUE;
            gnt        <= pick;
            last_grant <= pick;
            CMD_VALID  <= 1'b1;
            CMD_WRITE  <= (pick == GNT_WR);
            CMD_ADDR   <= (pick == GNT_WR) ? wr_addr : rd_addr;
            CMD_LEN    <= (pick == GNT_WR) ? wr_len : rd_len;
            BUSY       <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (CMD_READY) begin
            state     <= ST_WAIT_DONE;
            CMD_VALID <= 1'b0;
          end
        end
        ST_WAIT_DONE: begin
          if (CMD_DONE) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          CMD_VALID <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

  burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .BURST_LEN(BURST_LEN),
    .BASE     (WR_BASE),
    .MAX      (WR_MAX)
  ) u_wr_gen (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (WR_LOAD),
    .active    (wr_active),
    .done      (wr_done),
    .issue_addr(wr_addr),
    .issue_len (wr_len)
  );

  burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .BURST_LEN(BURST_LEN),
    .BASE     (RD_BASE),
    .MAX      (RD_MAX)
  ) u_rd_gen (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (RD_LOAD),
    .active    (rd_active),
    .done      (rd_done),
    .issue_addr(rd_addr),
    .issue_len (rd_len)
  );

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler with a transaction-rule reference model.
module tb_sdram_burst_scheduler;

  localparam int ADDR_W = 23;
  localparam int LEN_W  = 9;
  localparam int USED_W = 10;
  localparam int DEPTH  = 512;
  localparam int BLEN   = 256;
  localparam int W_BASE = 0;
  localparam int W_MAX  = 1000;
  localparam int R_BASE = 0;
  localparam int R_MAX  = 307200;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b1;
  logic              WR_LOAD = 1'b0, RD_LOAD = 1'b0;
  logic [USED_W-1:0] WR_USED = '0, RD_USED = 10'd512;
  logic              CMD_VALID, CMD_READY = 1'b1, CMD_WRITE, CMD_DONE = 1'b0, BUSY;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [LEN_W-1:0]  CMD_LEN;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  sdram_burst_scheduler #(.WR_MAX(W_MAX)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WR_LOAD(WR_LOAD), .RD_LOAD(RD_LOAD),
    .WR_USED(WR_USED), .RD_USED(RD_USED), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_DONE(CMD_DONE),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no burst, 1 = command offered, 2 = awaiting completion.
  int m_phase = 0, m_valid = 0, m_write = 0, m_addr = 0, m_len = 0, m_busy = 0;
  int wp = W_BASE, rp = R_BASE, wpend = 0, rpend = 0, m_last_wr = 0, m_gwr = 1;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_loads();
    if (WR_LOAD) begin if (m_gwr) wpend = 1; else wp = W_BASE; end
    if (RD_LOAD) begin if (!m_gwr) rpend = 1; else rp = R_BASE; end
  endtask

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_phase = 0; m_valid = 0; m_write = 0; m_addr = 0; m_len = 0; m_busy = 0;
      wp = W_BASE; rp = R_BASE; wpend = 0; rpend = 0; m_last_wr = 0; m_gwr = 1;
    end else begin
      case (m_phase)
        0: begin
          bit wreq, rreq;
          wreq = (int'(WR_USED) >= BLEN);
          rreq = (int'(RD_USED) <= DEPTH - BLEN);
          if (WR_LOAD) wp = W_BASE;
          if (RD_LOAD) rp = R_BASE;
          if (wreq || rreq) begin
            m_gwr     = wreq && !(rreq && m_last_wr);
            m_last_wr = m_gwr;
            m_write   = m_gwr;
            m_addr    = m_gwr ? wp : rp;
            m_len     = min_i(BLEN, (m_gwr ? W_MAX : R_MAX) - m_addr);
            m_valid   = 1; m_busy = 1; m_phase = 1;
          end
        end
        1: begin
          model_loads();
          if (CMD_READY) begin m_valid = 0; m_phase = 2; end
        end
        default: begin
          if (CMD_DONE) begin
            if (m_gwr) begin
              if (WR_LOAD || wpend) wp = W_BASE;
              else begin wp = wp + m_len; if (wp >= W_MAX) wp = W_BASE; end
              wpend = 0;
              if (RD_LOAD) rp = R_BASE;
            end else begin
              if (RD_LOAD || rpend) rp = R_BASE;
              else begin rp = rp + m_len; if (rp >= R_MAX) rp = R_BASE; end
              rpend = 0;
              if (WR_LOAD) wp = W_BASE;
            end
            m_phase = 0; m_busy = 0;
          end else model_loads();
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_valid", int'(CMD_VALID), m_valid);
      chk("cyc_busy",  int'(BUSY),      m_busy);
      chk("cyc_write", int'(CMD_WRITE), m_write);
      chk("cyc_addr",  int'(CMD_ADDR),  m_addr);
      chk("cyc_len",   int'(CMD_LEN),   m_len);
    end
  end

  task automatic step();
    @(posedge CLK); #2;
  endtask

  task automatic expect_cmd(input string nm, input int w, input int a, input int l);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (CMD_VALID) break;
    end
    chk({nm, "_valid"}, int'(CMD_VALID), 1);
    chk({nm, "_write"}, int'(CMD_WRITE), w);
    chk({nm, "_addr"},  int'(CMD_ADDR),  a);
    chk({nm, "_len"},   int'(CMD_LEN),   l);
  endtask

  // Assumes CMD_READY is high: the next edge is the handshake.
  task automatic finish_burst(input int nwu, input int nru, input logic [1:0] ld_wait,
                              input logic [1:0] ld_done);
    step();
    WR_USED = USED_W'(nwu); RD_USED = USED_W'(nru);
    {WR_LOAD, RD_LOAD} = ld_wait;
    step();
    {WR_LOAD, RD_LOAD} = ld_done;
    CMD_DONE = 1'b1;
    step();
    {WR_LOAD, RD_LOAD} = 2'b00;
    CMD_DONE = 1'b0;
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    cmp_en = 1;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_valid", int'(CMD_VALID), 0);
    chk("rst_busy",  int'(BUSY), 0);
    chk("rst_addr",  int'(CMD_ADDR), 0);
    RESET_N = 1'b1;
    WR_USED = 10'd300; RD_USED = 10'd100;

    // Contended: write first after reset, then alternate.
    expect_cmd("rr0", 1, 0, 256);   finish_burst(300, 100, 2'b00, 2'b00);
    expect_cmd("rr1", 0, 0, 256);   finish_burst(300, 100, 2'b00, 2'b00);
    expect_cmd("rr2", 1, 256, 256); finish_burst(300, 100, 2'b00, 2'b00);
    expect_cmd("rr3", 0, 256, 256); finish_burst(256, 400, 2'b00, 2'b00);

    // Rewind both while a write is in flight at pointer 512.
    expect_cmd("ld_w512", 1, 512, 256); finish_burst(256, 100, 2'b11, 2'b00);
    expect_cmd("ld_rd0",  0, 0, 256);   finish_burst(256, 400, 2'b00, 2'b00);
    expect_cmd("ld_wr0",  1, 0, 256);   finish_burst(256, 400, 2'b00, 2'b00);

    // Window end at 1000: last burst clipped, then wrap.
    expect_cmd("wrap1", 1, 256, 256); finish_burst(256, 400, 2'b00, 2'b00);
    expect_cmd("wrap2", 1, 512, 256); finish_burst(256, 400, 2'b00, 2'b00);
    expect_cmd("wrap3", 1, 768, 232); finish_burst(256, 400, 2'b00, 2'b00);
    expect_cmd("wrap4", 1, 0, 256);   finish_burst(0, 400, 2'b00, 2'b00);

    // Back-pressure for 10 cycles.
    CMD_READY = 1'b0; WR_USED = 10'd256;
    expect_cmd("stall", 1, 256, 256);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("stall_valid", int'(CMD_VALID), 1);
      chk("stall_addr",  int'(CMD_ADDR), 256);
      chk("stall_busy",  int'(BUSY), 1);
    end
    step(); CMD_READY = 1'b1;
    finish_burst(0, 400, 2'b00, 2'b00);

    // CMD_DONE in IDLE and ISSUE has no effect.
    CMD_DONE = 1'b1; step(); CMD_DONE = 1'b0;
    CMD_READY = 1'b0; RD_USED = 10'd0;
    expect_cmd("ign", 0, 256, 256);
    step(); CMD_DONE = 1'b1; step(); CMD_DONE = 1'b0;
    @(negedge CLK);
    chk("ign_valid", int'(CMD_VALID), 1);
    step(); CMD_READY = 1'b1;
    finish_burst(256, 400, 2'b00, 2'b00);

    // Load coinciding with completion wins.
    expect_cmd("ldd", 1, 512, 256); finish_burst(256, 400, 2'b00, 2'b10);
    expect_cmd("ldd0", 1, 0, 256);

    // Reset while awaiting completion.
    step(); WR_USED = 10'd0;
    step(); RESET_N = 1'b0;
    #1;
    chk("arst_valid", int'(CMD_VALID), 0);
    chk("arst_busy",  int'(BUSY), 0);
    chk("arst_write", int'(CMD_WRITE), 0);
    chk("arst_addr",  int'(CMD_ADDR), 0);
    chk("arst_len",   int'(CMD_LEN), 0);
    step(); RESET_N = 1'b1; WR_USED = 10'd300;
    expect_cmd("post_rst", 1, W_BASE, 256);
    finish_burst(0, 400, 2'b00, 2'b00);
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
